// File: rtl/voice_sequencer_pkg.sv
// Shared definitions for the voice step sequencer.
//   - Default widths (note index, pattern address, step/gate counters).
//   - Pattern entry layout {rest2, note2, rest1, note1} and field offsets.
//   - Sequencer state encoding.
//   - Helpers to pull fields out of an entry and to compute the next step.
package voice_sequencer_pkg;

    localparam int NOTE_W        = 4;
    localparam int DEPTH_W       = 4;
    localparam int CNT_W_DEFAULT = 18;
    localparam int DEPTH         = 1 << DEPTH_W;
    localparam int ENTRY_W       = 2 * NOTE_W + 2;

    // Entry field offsets.
    localparam int NOTE1_LSB = 0;
    localparam int REST1_BIT = 4;
    localparam int NOTE2_LSB = 5;
    localparam int REST2_BIT = 9;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    function automatic logic [NOTE_W-1:0] entry_note1(input entry_t e);
        return e[NOTE1_LSB +: NOTE_W];
    endfunction

    function automatic logic [NOTE_W-1:0] entry_note2(input entry_t e);
        return e[NOTE2_LSB +: NOTE_W];
    endfunction

    function automatic logic entry_rest1(input entry_t e);
        return e[REST1_BIT];
    endfunction

    function automatic logic entry_rest2(input entry_t e);
        return e[REST2_BIT];
    endfunction

    // Wrap with >= so that lowering the loop end below the step currently
    // playing still sends the sequence back to step 0 instead of running
    // on to the top of the pattern.
    function automatic logic [DEPTH_W-1:0] next_step(
        input logic [DEPTH_W-1:0] cur,
        input logic [DEPTH_W-1:0] last
    );
        return (cur >= last) ? '0 : cur + DEPTH_W'(1);
    endfunction

endpackage

// File: rtl/voice_sequencer_if.sv
// Control / pattern-write / voice-output bundle of the step sequencer.
//   master : the controller side (drives run, timing, loop end, pattern writes;
//            receives notes, gates, step index, step strobe, busy)
//   slave  : the sequencer itself
interface voice_sequencer_if
    import voice_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic               run;
    logic [CNT_W-1:0]   step_len;
    logic [CNT_W-1:0]   gate_len;
    logic [DEPTH_W-1:0] loop_last;
    logic               wr_en;
    logic [DEPTH_W-1:0] wr_addr;
    logic [ENTRY_W-1:0] wr_data;

    logic [NOTE_W-1:0]  note1;
    logic [NOTE_W-1:0]  note2;
    logic               gate1;
    logic               gate2;
    logic [DEPTH_W-1:0] step_idx;
    logic               step_strobe;
    logic               busy;

    modport master (
        output run, step_len, gate_len, loop_last, wr_en, wr_addr, wr_data,
        input  note1, note2, gate1, gate2, step_idx, step_strobe, busy
    );

    modport slave (
        input  run, step_len, gate_len, loop_last, wr_en, wr_addr, wr_data,
        output note1, note2, gate1, gate2, step_idx, step_strobe, busy
    );

endinterface

// File: rtl/voice_sequencer_seq_step_timer.sv
// Per-step cycle counter for the voice sequencer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : restart the count at 0 (first step after leaving idle)
//   en_i         : advance the count this cycle
//   step_len_i   : last cycle index of a step (step duration minus 1)
//   gate_len_i   : number of gate-high cycles at the start of a step
//   last_o       : the current cycle is the last one of the step
//   gate_win_o   : gate window for the cycle that starts on the next edge
// The gate window is evaluated on the next count value so the registered
// gates in the top line up with the count they belong to, and so a gate
// rises on the same edge that presents the new note.
module seq_step_timer #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] step_len_i,
    input  logic [CNT_W-1:0] gate_len_i,
    output logic             last_o,
    output logic             gate_win_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = (cnt_q == step_len_i);

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Forcing the window closed on the last cycle leaves at least one low
    // cycle per step, so the envelope retriggers even if gate_len>step_len.
    assign gate_win_o = (cnt_d < gate_len_i) && (cnt_d != step_len_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/voice_sequencer.sv
// Step sequencer driving two voice generators.
//   clk, rst_n : clock, asynchronous active-low reset
//   sif        : voice_sequencer_if.slave
//       run        level, 1 = play, 0 = stop
//       step_len   step duration minus 1 (clk cycles)
//       gate_len   gate-high cycles per step
//       loop_last  last step index before wrapping to 0
//       wr_en/wr_addr/wr_data  pattern write port, entry {rest2,note2,rest1,note1}
//       note1/note2  note indices for the scale ROMs
//       gate1/gate2  voice gates
//       step_idx     step currently playing
//       step_strobe  one-cycle pulse on the first cycle of each step
//       busy         high while playing
// The pattern is read only at a step fetch; a write to the step in progress
// therefore shows up on its next visit, and a write on the fetch edge of the
// same address returns the old entry.
module voice_sequencer
    import voice_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    voice_sequencer_if.slave sif
);

    state_e             state_q, state_d;
    entry_t             mem_q [DEPTH];

    logic [NOTE_W-1:0]  note1_q, note1_d;
    logic [NOTE_W-1:0]  note2_q, note2_d;
    logic               rest1_q, rest1_d;
    logic               rest2_q, rest2_d;
    logic               gate1_q, gate1_d;
    logic               gate2_q, gate2_d;
    logic               strobe_q, strobe_d;
    logic [DEPTH_W-1:0] idx_q, idx_d;

    logic               tmr_start;
    logic               tmr_en;
    logic               step_last;
    logic               gate_win;
    logic               fetch;
    logic [DEPTH_W-1:0] fetch_addr;
    entry_t             fetch_entry;

    seq_step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (tmr_start),
        .en_i       (tmr_en),
        .step_len_i (sif.step_len),
        .gate_len_i (sif.gate_len),
        .last_o     (step_last),
        .gate_win_o (gate_win)
    );

    always_comb begin
        state_d    = state_q;
        note1_d    = note1_q;
        note2_d    = note2_q;
        rest1_d    = rest1_q;
        rest2_d    = rest2_q;
        idx_d      = idx_q;
        strobe_d   = 1'b0;
        gate1_d    = 1'b0;
        gate2_d    = 1'b0;
        tmr_start  = 1'b0;
        tmr_en     = 1'b0;
        fetch      = 1'b0;
        fetch_addr = '0;

        case (state_q)
            ST_IDLE: begin
                // Every start replays from step 0.
                if (sif.run) begin
                    state_d   = ST_PLAY;
                    fetch     = 1'b1;
                    tmr_start = 1'b1;
                end
            end
            ST_PLAY: begin
                if (!sif.run) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                    if (step_last) begin
                        fetch      = 1'b1;
                        fetch_addr = next_step(idx_q, sif.loop_last);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fetch_entry = mem_q[fetch_addr];

        if (fetch) begin
            idx_d    = fetch_addr;
            note1_d  = entry_note1(fetch_entry);
            note2_d  = entry_note2(fetch_entry);
            rest1_d  = entry_rest1(fetch_entry);
            rest2_d  = entry_rest2(fetch_entry);
            strobe_d = 1'b1;
        end

        // Rest flags come from the step that will be playing after this edge.
        if (state_d == ST_PLAY) begin
            gate1_d = gate_win && !rest1_d;
            gate2_d = gate_win && !rest2_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            note1_q  <= '0;
            note2_q  <= '0;
            rest1_q  <= 1'b0;
            rest2_q  <= 1'b0;
            gate1_q  <= 1'b0;
            gate2_q  <= 1'b0;
            strobe_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            note1_q  <= note1_d;
            note2_q  <= note2_d;
            rest1_q  <= rest1_d;
            rest2_q  <= rest2_d;
            gate1_q  <= gate1_d;
            gate2_q  <= gate2_d;
            strobe_q <= strobe_d;
            idx_q    <= idx_d;
        end
    end

    // Pattern store: flops so it can be cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (sif.wr_en) begin
            mem_q[sif.wr_addr] <= sif.wr_data;
        end
    end

    assign sif.note1       = note1_q;
    assign sif.note2       = note2_q;
    assign sif.gate1       = gate1_q;
    assign sif.gate2       = gate2_q;
    assign sif.step_idx    = idx_q;
    assign sif.step_strobe = strobe_q;
    assign sif.busy        = (state_q == ST_PLAY);

endmodule

// File: tb/tb_voice_sequencer.sv
// Scoreboard bench for voice_sequencer: the driver predicts each step that
// should play and queues it; a monitor pops on every step_strobe and checks
// the step index, notes, strobe spacing and per-cycle gates.
module tb_voice_sequencer;
    import voice_sequencer_pkg::*;

    localparam int CW = CNT_W_DEFAULT;

    logic clk;
    logic rst_n;

    voice_sequencer_if #(.CNT_W(CW)) sif ();

    voice_sequencer #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int n1;
        int n2;
        bit r1;
        bit r2;
    } step_rec_t;

    int          vectors     = 0;
    int          miscompares = 0;
    step_rec_t   exp_q[$];
    logic [9:0]  model_mem [16];
    bit          mon_en      = 1'b0;
    int          seg_step_len = 0;
    int          seg_gate_len = 0;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_note1"},  int'(sif.note1), 0);
        check({tag, "_note2"},  int'(sif.note2), 0);
        check({tag, "_gate1"},  int'(sif.gate1), 0);
        check({tag, "_gate2"},  int'(sif.gate2), 0);
        check({tag, "_idx"},    int'(sif.step_idx), 0);
        check({tag, "_strobe"}, int'(sif.step_strobe), 0);
        check({tag, "_busy"},   int'(sif.busy), 0);
    endtask

    // Monitor: one step record per strobe; gates within a step are high
    // for the first min(gate_len, step_len) cycles unless the voice rests.
    initial begin : monitor
        step_rec_t cur;
        bit        active;
        int        c;
        int        len;
        int        gmin;
        active = 1'b0;
        c      = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n || sif.busy !== 1'b1) begin
                active = 1'b0;
                continue;
            end
            len  = seg_step_len + 1;
            gmin = (seg_gate_len < seg_step_len) ? seg_gate_len : seg_step_len;
            if (active) begin
                check("strobe_spacing", int'(sif.step_strobe), int'(c == len));
            end
            if (sif.step_strobe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_step: got idx %0d, expected no step", sif.step_idx);
                    active = 1'b0;
                    continue;
                end
                cur    = exp_q.pop_front();
                active = 1'b1;
                c      = 0;
                $display("step idx=%0d note1=%0d note2=%0d rest1=%0d rest2=%0d",
                         sif.step_idx, sif.note1, sif.note2, cur.r1, cur.r2);
                check("step_idx", int'(sif.step_idx), cur.idx);
                check("note1",    int'(sif.note1),    cur.n1);
                check("note2",    int'(sif.note2),    cur.n2);
            end
            if (active) begin
                check("gate1", int'(sif.gate1), int'((c < gmin) && !cur.r1));
                check("gate2", int'(sif.gate2), int'((c < gmin) && !cur.r2));
                c++;
            end
        end
    end

    task automatic write_entry(input int a, input logic [9:0] d);
        @(negedge clk);
        sif.wr_en   = 1'b1;
        sif.wr_addr = 4'(a);
        sif.wr_data = d;
        @(negedge clk);
        sif.wr_en   = 1'b0;
        model_mem[a] = d;
    endtask

    // Plays k steps then stops. Optionally writes (wa, wd) during cycle w of
    // the first step; a visit whose fetch edge comes after the write edge
    // sees the new entry, one on the same edge or earlier sees the old one.
    task automatic play_segment(input int sl, input int gl, input int ll, input int k,
                                input bit do_wr, input int wa, input logic [9:0] wd,
                                input int w);
        int         len;
        int         idx;
        int         last_idx;
        int         last_n1;
        int         last_n2;
        logic [9:0] e;
        step_rec_t  r;
        len      = sl + 1;
        idx      = 0;
        last_idx = 0;
        last_n1  = 0;
        last_n2  = 0;
        seg_step_len  = sl;
        seg_gate_len  = gl;
        sif.step_len  = CW'(sl);
        sif.gate_len  = CW'(gl);
        sif.loop_last = 4'(ll);
        sif.wr_addr   = 4'(wa);
        sif.wr_data   = wd;
        for (int v = 0; v < k; v++) begin
            e = (do_wr && idx == wa && v * len > w + 1) ? wd : model_mem[idx];
            r.idx = idx;
            r.n1  = int'(e[3:0]);
            r.n2  = int'(e[8:5]);
            r.r1  = e[4];
            r.r2  = e[9];
            exp_q.push_back(r);
            last_idx = idx;
            last_n1  = r.n1;
            last_n2  = r.n2;
            idx = (idx >= ll) ? 0 : idx + 1;
        end
        mon_en = 1'b1;
        @(negedge clk);
        sif.run = 1'b1;
        for (int t = 0; t < k * len; t++) begin
            @(negedge clk);
            sif.wr_en = do_wr && (t == w);
            if (t == k * len - 1) sif.run = 1'b0;
        end
        sif.wr_en = 1'b0;
        @(negedge clk);
        check("stop_busy",   int'(sif.busy), 0);
        check("stop_gate1",  int'(sif.gate1), 0);
        check("stop_gate2",  int'(sif.gate2), 0);
        check("stop_strobe", int'(sif.step_strobe), 0);
        check("hold_idx",    int'(sif.step_idx), last_idx);
        check("hold_note1",  int'(sif.note1), last_n1);
        check("hold_note2",  int'(sif.note2), last_n2);
        check("steps_left",  exp_q.size(), 0);
        exp_q.delete();
        mon_en = 1'b0;
        if (do_wr) model_mem[wa] = wd;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int         sl, gl, ll, k, wa, w, nw;
        bit         do_wr;
        bit         found;
        logic [9:0] wd;

        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        rst_n         = 1'b0;
        sif.run       = 1'b1;
        sif.step_len  = '0;
        sif.gate_len  = '0;
        sif.loop_last = '0;
        sif.wr_en     = 1'b0;
        sif.wr_addr   = '0;
        sif.wr_data   = '0;

        // Reset with run held: outputs stay 0, first strobe one cycle after release.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("first_strobe", int'(sif.step_strobe), 1);
        check("first_idx",    int'(sif.step_idx), 0);
        check("first_busy",   int'(sif.busy), 1);
        check("first_gate1",  int'(sif.gate1), 0);
        sif.run = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(sif.busy), 0);

        // Basic 4-step loop, notes n and n+3.
        for (int n = 0; n < 4; n++) write_entry(n, {1'b0, 4'(n + 3), 1'b0, 4'(n)});
        play_segment(9, 5, 3, 5, 1'b0, 0, '0, 0);
        // Gate longer than step: still low on the last cycle.
        play_segment(9, 20, 3, 5, 1'b0, 0, '0, 0);
        // Voice 1 rests on step 1.
        write_entry(1, {1'b0, 4'd4, 1'b1, 4'd1});
        play_segment(9, 5, 3, 4, 1'b0, 0, '0, 0);
        // Rewrite step 0 while it plays: next visit shows note1=9.
        play_segment(9, 5, 3, 6, 1'b1, 0, {1'b0, 4'd3, 1'b0, 4'd9}, 4);
        // Write on the same edge that fetches step 1: old entry first.
        play_segment(4, 2, 3, 6, 1'b1, 1, {1'b1, 4'd12, 1'b0, 4'd11}, 4);
        // Degenerate timing.
        play_segment(0, 3, 3, 6, 1'b0, 0, '0, 0);
        play_segment(5, 0, 2, 4, 1'b0, 0, '0, 0);

        // Lower loop_last below the playing step, then stop mid-step.
        write_entry(0, {1'b0, 4'd5, 1'b0, 4'd6});
        sif.step_len  = CW'(3);
        sif.gate_len  = CW'(4);
        sif.loop_last = 4'd3;
        @(negedge clk);
        sif.run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (sif.step_strobe === 1'b1 && sif.step_idx === 4'd2) found = 1'b1;
        end
        check("reach_step2", int'(found), 1);
        sif.loop_last = 4'd1;
        repeat (4) @(negedge clk);
        check("wrap_strobe", int'(sif.step_strobe), 1);
        check("wrap_idx",    int'(sif.step_idx), 0);
        @(negedge clk);
        check("midstep_gate1", int'(sif.gate1), 1);
        sif.run = 1'b0;
        @(negedge clk);
        check("halt_gate1", int'(sif.gate1), 0);
        check("halt_gate2", int'(sif.gate2), 0);
        check("halt_busy",  int'(sif.busy), 0);
        check("halt_idx",   int'(sif.step_idx), 0);
        check("halt_note1", int'(sif.note1), 6);

        // Asynchronous reset mid-step clears outputs at once and the pattern.
        sif.step_len = CW'(5);
        sif.run = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        sif.run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        play_segment(3, 2, 7, 10, 1'b0, 0, '0, 0);

        // Randomised segments.
        repeat (14) begin
            nw = $urandom_range(1, 5);
            repeat (nw) write_entry($urandom_range(0, 15), 10'($urandom));
            sl    = $urandom_range(0, 7);
            gl    = $urandom_range(0, 10);
            ll    = $urandom_range(0, 6);
            k     = $urandom_range(2, 9);
            do_wr = 1'($urandom_range(0, 1));
            wa    = $urandom_range(0, 15);
            wd    = 10'($urandom);
            w     = $urandom_range(0, sl);
            play_segment(sl, gl, ll, k, do_wr, wa, wd, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
